// File: rtl/game_controller.sv
// Pong match sequencer.
//
// Turns the ball tracker's point and paddle-hit flags into per-player scores,
// a rally count and a winner. Walks the match through serve delay, live play,
// the pause after each point, and game over. The start button begins a match.
//
// Ports:
//   clk           in   50 MHz master clock
//   reset         in   synchronous, active-low reset
//   start         in   debounced start button; only rising edges act
//   player1_point in   level flag from the ball tracker, player 1 scored
//   player2_point in   level flag from the ball tracker, player 2 scored
//   paddle_hit    in   level flag from the ball tracker, ball hit a paddle
//   game_on       out  high only while the ball is in play
//   ball_rst_n    out  active-low re-centre reset to the ball tracker
//   score1        out  player 1 score
//   score2        out  player 2 score
//   rally         out  paddle hits in the current point, saturating at 255
//   winner        out  00 none, 01 player 1, 10 player 2
module game_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned POINT_PAUSE = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player1_point,
  input  logic       player2_point,
  input  logic       paddle_hit,
  output logic       game_on,
  output logic       ball_rst_n,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [7:0] rally,
  output logic [1:0] winner
);

  localparam int unsigned MaxDelay = (SERVE_DELAY > POINT_PAUSE) ? SERVE_DELAY : POINT_PAUSE;
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);

  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_DELAY - 1);
  localparam logic [CntW-1:0] PauseLast = CntW'(POINT_PAUSE - 1);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPoint, StOver} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            start_q, p1_q, p2_q, hit_q;
  logic            start_edge, p1_edge, p2_edge, hit_edge;

  // The *_q copies follow their inputs every cycle, so a flag already high
  // when PLAY is entered never produces an edge.
  assign start_edge = start & ~start_q;
  assign p1_edge    = player1_point & ~p1_q;
  assign p2_edge    = player2_point & ~p2_q;
  assign hit_edge   = paddle_hit & ~hit_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      hit_q      <= 1'b0;
      game_on    <= 1'b0;
      ball_rst_n <= 1'b0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      rally      <= 8'd0;
      winner     <= 2'b00;
    end else begin
      start_q <= start;
      p1_q    <= player1_point;
      p2_q    <= player2_point;
      hit_q   <= paddle_hit;

      case (state_q)
        StIdle, StOver: begin
          if (start_edge) begin
            state_q    <= StServe;
            cnt_q      <= '0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            rally      <= 8'd0;
            winner     <= 2'b00;
            game_on    <= 1'b0;
            ball_rst_n <= 1'b0;
          end
        end

        StServe: begin
          if (cnt_q == ServeLast) begin
            state_q    <= StPlay;
            cnt_q      <= '0;
            game_on    <= 1'b1;
            ball_rst_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StPlay: begin
          if (p1_edge || p2_edge) begin
            // Simultaneous points cancel and the point is simply re-served.
            if (p1_edge && !p2_edge) score1 <= score1 + 4'd1;
            if (p2_edge && !p1_edge) score2 <= score2 + 4'd1;
            state_q    <= StPoint;
            cnt_q      <= '0;
            game_on    <= 1'b0;
            ball_rst_n <= 1'b0;
          end else if (hit_edge && (rally != 8'hff)) begin
            rally <= rally + 8'd1;
          end
        end

        StPoint: begin
          if (cnt_q == PauseLast) begin
            cnt_q <= '0;
            if (score1 == WinScore) begin
              state_q <= StOver;
              winner  <= 2'b01;
            end else if (score2 == WinScore) begin
              state_q <= StOver;
              winner  <= 2'b10;
            end else begin
              state_q <= StServe;
              rally   <= 8'd0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        default: begin
          state_q    <= StIdle;
          cnt_q      <= '0;
          game_on    <= 1'b0;
          ball_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  localparam int Win = 2;
  localparam int Sd  = 4;
  localparam int Pp  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       player1_point = 1'b0;
  logic       player2_point = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       game_on, ball_rst_n;
  logic [3:0] score1, score2;
  logic [7:0] rally;
  logic [1:0] winner;

  game_controller #(
    .WIN_SCORE  (Win),
    .SERVE_DELAY(Sd),
    .POINT_PAUSE(Pp)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .player1_point(player1_point),
    .player2_point(player2_point),
    .paddle_hit   (paddle_hit),
    .game_on      (game_on),
    .ball_rst_n   (ball_rst_n),
    .score1       (score1),
    .score2       (score2),
    .rally        (rally),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a match phase plus a countdown of cycles left in it.
  localparam int MIdle = 0, MServe = 1, MPlay = 2, MPoint = 3, MOver = 4;
  int m_mode, m_left, m_s1, m_s2, m_rally, m_win;
  bit pv_start, pv_p1, pv_p2, pv_hit;

  always @(posedge clk) begin
    bit se, e1, e2, eh;
    if (!reset) begin
      m_mode = MIdle; m_left = 0; m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0;
      pv_start = 0; pv_p1 = 0; pv_p2 = 0; pv_hit = 0;
    end else begin
      se = start && !pv_start;
      e1 = player1_point && !pv_p1;
      e2 = player2_point && !pv_p2;
      eh = paddle_hit && !pv_hit;
      pv_start = start; pv_p1 = player1_point; pv_p2 = player2_point; pv_hit = paddle_hit;
      if (m_mode == MIdle || m_mode == MOver) begin
        if (se) begin
          m_mode = MServe; m_left = Sd; m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0;
        end
      end else if (m_mode == MServe) begin
        m_left--;
        if (m_left == 0) m_mode = MPlay;
      end else if (m_mode == MPlay) begin
        if (e1 || e2) begin
          if (e1 && !e2) m_s1++;
          if (e2 && !e1) m_s2++;
          m_mode = MPoint; m_left = Pp;
        end else if (eh && m_rally < 255) begin
          m_rally++;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == Win) begin
            m_mode = MOver; m_win = 1;
          end else if (m_s2 == Win) begin
            m_mode = MOver; m_win = 2;
          end else begin
            m_mode = MServe; m_left = Sd; m_rally = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_game_on", int'(game_on), int'(m_mode == MPlay));
      check("model_ball_rst_n", int'(ball_rst_n), int'(m_mode == MPlay));
      check("model_score1", int'(score1), m_s1);
      check("model_score2", int'(score2), m_s2);
      check("model_rally", int'(rally), m_rally);
      check("model_winner", int'(winner), m_win);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic wait_play(input int budget);
    for (int i = 0; i < budget && game_on !== 1'b1; i++) cyc(1);
    check("wait_play", int'(game_on), 1);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    check("rst_game_on", int'(game_on), 0);
    check("rst_ball_rst_n", int'(ball_rst_n), 0);
    check("rst_scores", int'({score1, score2}), 0);
    check("rst_rally", int'(rally), 0);
    check("rst_winner", int'(winner), 0);
    reset = 1'b1;
    cyc(3);

    // Start: game_on exactly Sd edges after the start edge
    pulse_start();
    check("serve_ball_rst_n", int'(ball_rst_n), 0);
    cyc(Sd - 1);
    check("serve_not_early", int'(game_on), 0);
    cyc(1);
    check("serve_game_on", int'(game_on), 1);
    check("serve_ball_rst_n_hi", int'(ball_rst_n), 1);
    cyc(3);

    // Held player1 flag counts once, pause then re-serve
    player1_point = 1'b1;
    cyc(1);
    check("p1_score", int'(score1), 1);
    check("p1_game_on_low", int'(game_on), 0);
    cyc(Pp + Sd - 1);
    check("p1_reserve_not_early", int'(game_on), 0);
    cyc(1);
    check("p1_reserve_game_on", int'(game_on), 1);
    cyc(2);
    player1_point = 1'b0;
    cyc(1);
    check("p1_held_once", int'(score1), 1);

    // Two player2 points win the match
    player2_point = 1'b1; cyc(1); player2_point = 1'b0;
    wait_play(20);
    player2_point = 1'b1; cyc(1); player2_point = 1'b0;
    check("p2_score2", int'(score2), 2);
    cyc(Pp);
    check("over_winner", int'(winner), 2);
    check("over_game_on", int'(game_on), 0);
    player1_point = 1'b1; cyc(1); player1_point = 1'b0; cyc(1);
    check("over_ignores_point", int'(score1), 1);
    pulse_start();
    check("restart_clear", int'({score1, score2, winner}), 0);
    cyc(Sd);
    check("restart_game_on", int'(game_on), 1);

    // Simultaneous points: no score, re-serve
    player1_point = 1'b1; player2_point = 1'b1;
    cyc(1);
    player1_point = 1'b0; player2_point = 1'b0;
    check("both_scores", int'({score1, score2}), 0);
    check("both_game_on", int'(game_on), 0);
    wait_play(20);

    // Rally saturation, then cleared by the next serve
    for (int i = 0; i < 300; i++) begin
      paddle_hit = 1'b1; cyc(1); paddle_hit = 1'b0; cyc(1);
    end
    check("rally_sat", int'(rally), 255);
    player1_point = 1'b1; cyc(1); player1_point = 1'b0;
    wait_play(20);
    check("rally_cleared", int'(rally), 0);

    // Reset mid-SERVE with two serve cycles counted
    player2_point = 1'b1; cyc(1); player2_point = 1'b0;
    cyc(Pp + 2);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    check("midrst_outputs",
          int'({game_on, ball_rst_n, score1, score2, rally, winner}), 0);
    cyc(2);
    pulse_start();
    cyc(Sd - 1);
    check("midrst_serve_not_early", int'(game_on), 0);
    cyc(1);
    check("midrst_serve_full", int'(game_on), 1);

    // Random play against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 8) player1_point = ~player1_point;
      if ($urandom_range(0, 99) < 8) player2_point = ~player2_point;
      paddle_hit = ($urandom_range(0, 99) < 40);
      reset = ($urandom_range(0, 999) != 0);
      cyc(1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
